// File: rtl/ts4231_cfg_scheduler.sv
// Serialises TS4231 init-engine configuration: start one sensor at a time, wait for done
// with a timeout, verify the readback word, retry, and publish sticky per-sensor ok/fail.
module ts4231_cfg_scheduler #(
  parameter int          NUM_SENSORS    = 4,
  parameter logic [14:0] EXPECTED_CFG   = 15'h392B,
  parameter int          TIMEOUT_CYCLES = 4_800_000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rescan,
  output logic [NUM_SENSORS-1:0]   start_cfg,
  input  logic [NUM_SENSORS-1:0]   cfg_done,
  input  logic [15*NUM_SENSORS-1:0] cfg_data_reply,
  output logic [NUM_SENSORS-1:0]   sensor_ok,
  output logic [NUM_SENSORS-1:0]   sensor_fail,
  output logic [3:0]               active_idx,
  output logic                     busy,
  output logic                     pass_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [3:0]    IDX_LAST  = 4'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {IDLE, START, ARM, WAIT, CHECK, ADVANCE, FINISH} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             idx;
  logic [RW-1:0]          retry;
  logic [TW-1:0]          tcnt;
  logic [NUM_SENSORS-1:0] sel;
  logic                   done_sel;
  logic [14:0]            reply_sel;
  logic                   timeout, attempt_bad;
  logic                   clr_status, set_ok, set_fail, retry_inc, idx_inc;

  // Decode the served sensor with constant indices so narrow buses never see a 4-bit index.
  always_comb begin
    sel       = '0;
    done_sel  = 1'b0;
    reply_sel = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (idx == 4'(i)) begin
        sel[i]    = 1'b1;
        done_sel  = cfg_done[i];
        reply_sel = cfg_data_reply[15*i +: 15];
      end
    end
  end

  assign timeout = (tcnt == TMO_LAST);

  always_comb begin
    state_nxt   = state;
    attempt_bad = 1'b0;
    clr_status  = 1'b0;
    set_ok      = 1'b0;
    set_fail    = 1'b0;
    retry_inc   = 1'b0;
    idx_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && rescan) begin
          clr_status = 1'b1;
          state_nxt  = START;
        end
      end
      START: state_nxt = ARM;
      ARM: begin
        if (!done_sel)    state_nxt = WAIT;
        else if (timeout) attempt_bad = 1'b1;
      end
      WAIT: begin
        // A done rising on the expiry cycle still counts as a completed attempt.
        if (done_sel)     state_nxt = CHECK;
        else if (timeout) attempt_bad = 1'b1;
      end
      CHECK: begin
        if (reply_sel == EXPECTED_CFG) begin
          set_ok    = 1'b1;
          state_nxt = ADVANCE;
        end else begin
          attempt_bad = 1'b1;
        end
      end
      ADVANCE: begin
        if (idx == IDX_LAST) begin
          state_nxt = FINISH;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = START;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (attempt_bad) begin
      if (retry < RETRY_MAX) begin
        retry_inc = 1'b1;
        state_nxt = START;
      end else begin
        set_fail  = 1'b1;
        state_nxt = ADVANCE;
      end
    end

    // Abort leaves undecided sensors untouched, including the one being checked.
    if (state != IDLE && !enable) begin
      state_nxt = IDLE;
      set_ok    = 1'b0;
      set_fail  = 1'b0;
      retry_inc = 1'b0;
      idx_inc   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      retry       <= '0;
      tcnt        <= '0;
      sensor_ok   <= '0;
      sensor_fail <= '0;
    end else begin
      state <= state_nxt;
      if (clr_status) begin
        sensor_ok   <= '0;
        sensor_fail <= '0;
        idx         <= '0;
        retry       <= '0;
      end
      if (set_ok)    sensor_ok   <= sensor_ok | sel;
      if (set_fail)  sensor_fail <= sensor_fail | sel;
      if (retry_inc) retry <= retry + RW'(1);
      if (idx_inc) begin
        idx   <= idx + 4'd1;
        retry <= '0;
      end
      if (state == START)
        tcnt <= '0;
      else if ((state == ARM || state == WAIT) && tcnt != '1)
        tcnt <= tcnt + TW'(1);
    end
  end

  assign start_cfg  = (state == START) ? sel : '0;
  assign busy       = (state != IDLE) && (state != FINISH);
  assign pass_done  = (state == FINISH);
  assign active_idx = busy ? idx : 4'd0;

endmodule

// File: tb/tb_ts4231_cfg_scheduler.sv
// Scoreboard bench for ts4231_cfg_scheduler with behavioural init-engine models.
module tb_ts4231_cfg_scheduler;

  localparam int NS  = 4;
  localparam int TMO = 100;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             rescan = 1'b0;
  logic [NS-1:0]    start_cfg, cfg_done, sensor_ok, sensor_fail;
  logic [15*NS-1:0] cfg_data_reply;
  logic [3:0]       active_idx;
  logic             busy, pass_done;

  ts4231_cfg_scheduler #(
    .NUM_SENSORS(NS), .EXPECTED_CFG(15'h392B), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .rescan(rescan),
    .start_cfg(start_cfg), .cfg_done(cfg_done), .cfg_data_reply(cfg_data_reply),
    .sensor_ok(sensor_ok), .sensor_fail(sensor_fail), .active_idx(active_idx),
    .busy(busy), .pass_done(pass_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] idx_of(input logic [NS-1:0] oh);
    idx_of = 4'd0;
    for (int i = 0; i < NS; i++) if (oh[i]) idx_of = 4'(i);
  endfunction

  // Engine model: done drops drop_age cycles after start and rises at rise_age.
  int age[NS];
  int attempts[NS];
  int drop_age[NS];
  int rise_age[NS];
  int bad_n[NS];
  bit stuck[NS];
  bit started[NS];

  always @(negedge clock) begin
    for (int i = 0; i < NS; i++) begin
      if (start_cfg[i]) begin
        age[i] = 0;
        attempts[i]++;
        started[i] = 1'b1;
      end else if (age[i] < 1000000) begin
        age[i]++;
      end
      if (stuck[i])
        cfg_done[i] = 1'b1;
      else if (started[i] && age[i] >= drop_age[i])
        cfg_done[i] = (age[i] >= rise_age[i]);
      cfg_data_reply[15*i +: 15] = (attempts[i] > bad_n[i]) ? 15'h392B : 15'h392A;
    end
  end

  // Scoreboard: expected start pulses and end-of-pass status.
  logic [NS-1:0]   exp_start[$];
  logic [2*NS-1:0] exp_stat[$];
  int              cyc = 0;
  int              last_start_cyc = 0;
  logic [NS-1:0]   last_start = '0;
  bit              gap_chk = 1'b0;

  always @(negedge clock) begin
    logic [NS-1:0]   e;
    logic [2*NS-1:0] s;
    cyc++;
    if (start_cfg != '0) begin
      if (exp_start.size() == 0) begin
        check("start_unexpected", start_cfg, 0);
      end else begin
        e = exp_start.pop_front();
        check("start_cfg", start_cfg, e);
        check("active_idx", active_idx, idx_of(e));
      end
      if (gap_chk && start_cfg == last_start && start_cfg == 4'b0010)
        check("retry_gap", cyc - last_start_cyc, TMO + 1);
      last_start     = start_cfg;
      last_start_cyc = cyc;
    end
    if (pass_done) begin
      if (exp_stat.size() == 0) begin
        check("pass_unexpected", pass_done, 0);
      end else begin
        s = exp_stat.pop_front();
        check("pass_ok", sensor_ok, s[2*NS-1:NS]);
        check("pass_fail", sensor_fail, s[NS-1:0]);
        check("pass_busy", busy, 0);
      end
    end
  end

  task automatic configure();
    for (int i = 0; i < NS; i++) begin
      drop_age[i] = 2;
      rise_age[i] = 52;
      bad_n[i]    = 0;
      stuck[i]    = 1'b0;
      attempts[i] = 0;
    end
  endtask

  task automatic go();
    @(negedge clock) rescan = 1'b1;
    @(negedge clock) rescan = 1'b0;
  endtask

  task automatic wait_pass(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (pass_done) seen = 1'b1;
    end
    check("pass_seen", seen, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    for (int i = 0; i < NS; i++) begin
      age[i] = 1000000;
      started[i] = 1'b0;
    end
    configure();
    cfg_done       = '0;
    cfg_data_reply = '0;

    repeat (3) @(negedge clock);
    check("rst_start", start_cfg, 0);
    check("rst_ok", sensor_ok, 0);
    check("rst_fail", sensor_fail, 0);
    check("rst_idx", active_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_pass", pass_done, 0);
    reset = 1'b0;

    go();
    repeat (3) @(negedge clock);
    check("busy_noenable", busy, 0);

    // All sensors respond correctly; a rescan mid-pass is ignored.
    enable = 1'b1;
    configure();
    exp_start.push_back(4'b0001); exp_start.push_back(4'b0010);
    exp_start.push_back(4'b0100); exp_start.push_back(4'b1000);
    exp_stat.push_back({4'b1111, 4'b0000});
    go();
    check("busy_start", busy, 1);
    repeat (20) @(negedge clock);
    rescan = 1'b1;
    @(negedge clock) rescan = 1'b0;
    wait_pass(2000);
    check("q_empty_s1", exp_start.size(), 0);

    // Sensor 2 replies wrong twice.
    configure();
    bad_n[2] = 2;
    exp_start.push_back(4'b0001); exp_start.push_back(4'b0010);
    for (int k = 0; k < 3; k++) exp_start.push_back(4'b0100);
    exp_start.push_back(4'b1000);
    exp_stat.push_back({4'b1111, 4'b0000});
    go();
    wait_pass(2000);
    check("q_empty_s2", exp_start.size(), 0);

    // Sensor 1 never drops done: four timed-out attempts.
    configure();
    stuck[1] = 1'b1;
    gap_chk  = 1'b1;
    exp_start.push_back(4'b0001);
    for (int k = 0; k < 4; k++) exp_start.push_back(4'b0010);
    exp_start.push_back(4'b0100); exp_start.push_back(4'b1000);
    exp_stat.push_back({4'b1101, 4'b0010});
    go();
    wait_pass(3000);
    gap_chk  = 1'b0;
    stuck[1] = 1'b0;
    check("q_empty_s3", exp_start.size(), 0);

    // Abort while sensor 2 is in WAIT, then rescan.
    configure();
    exp_start.push_back(4'b0001); exp_start.push_back(4'b0010); exp_start.push_back(4'b0100);
    go();
    reached = 1'b0;
    for (int k = 0; k < 500 && !reached; k++) begin
      @(negedge clock);
      if (active_idx == 4'd2) reached = 1'b1;
    end
    check("reach_idx2", reached, 1);
    repeat (10) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_start", start_cfg, 0);
    check("abort_ok", sensor_ok, 4'b0011);
    check("abort_fail", sensor_fail, 0);
    check("abort_idx", active_idx, 0);
    repeat (5) @(negedge clock);
    check("q_empty_s4", exp_start.size(), 0);
    enable = 1'b1;
    configure();
    exp_start.push_back(4'b0001); exp_start.push_back(4'b0010);
    exp_start.push_back(4'b0100); exp_start.push_back(4'b1000);
    exp_stat.push_back({4'b1111, 4'b0000});
    go();
    check("rescan_cleared", sensor_ok, 0);
    wait_pass(2000);

    // Sensor 0 done rises on the timeout-expiry cycle.
    configure();
    rise_age[0] = TMO;
    exp_start.push_back(4'b0001); exp_start.push_back(4'b0010);
    exp_start.push_back(4'b0100); exp_start.push_back(4'b1000);
    exp_stat.push_back({4'b1111, 4'b0000});
    go();
    wait_pass(2000);
    check("exact_tmo_attempts", attempts[0], 1);
    check("q_empty_s5", exp_start.size(), 0);

    // Reset during START with rescan held.
    configure();
    exp_start.push_back(4'b0001);
    @(negedge clock) rescan = 1'b1;
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check("rstx_start", start_cfg, 0);
    check("rstx_busy", busy, 0);
    check("rstx_idx", active_idx, 0);
    check("rstx_ok", sensor_ok, 0);
    check("rstx_fail", sensor_fail, 0);
    check("rstx_pass", pass_done, 0);
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    rescan = 1'b0;
    repeat (5) @(negedge clock);
    check("rstx_idle", busy, 0);
    check("q_empty_s6", exp_start.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
